// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
//   Shared types and helpers for the req_grant_arbiter slice.
//   - arb_state_e : arbiter ownership state (IDLE = nobody holds the grant,
//                   OWNED = exactly one requester holds it)
//   - idx_w()     : width of a requester index for an N-way arbiter
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Index width for N requesters; never collapses below one bit.
  function automatic int idx_w(input int n);
    int w;
    if (n > 1) begin
      w = $clog2(n);
    end else begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/req_grant_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin winner search.
//   Ports:
//     req      in  N   raw request vector
//     mask     in  N   1 = requester is eligible for this pick
//     last_ptr in  IW  index of the previous winner; search starts one above it
//     onehot   out N   one-hot winner (zero when nothing eligible)
//     idx      out IW  winner index (zero when nothing eligible)
//     any      out 1   at least one eligible requester
// ---------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] last_ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] cand;

  // Walk the eligible requests starting at last_ptr+1, wrapping modulo N;
  // the first hit wins and later hits are ignored.
  always_comb begin
    cand   = req & mask;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!any && cand[(int'(last_ptr) + k) % N]) begin
        any                                 = 1'b1;
        onehot[(int'(last_ptr) + k) % N]    = 1'b1;
        idx                                 = IW'((int'(last_ptr) + k) % N);
      end else begin
        // earlier winner (or no candidate yet) stands
        any = any;
      end
    end
  end

endmodule

// File: rtl/req_grant_arbiter.sv
// ---------------------------------------------------------------------------
// req_grant_arbiter
//   N-way round-robin arbiter with a bounded hold time. An owner keeps the
//   grant while its request stays high; after MAX_HOLD consecutive cycles it
//   is rotated out only if someone else is waiting.
//   Ports:
//     clk          in  1   clock, all logic on posedge
//     rst_n        in  1   synchronous active-low reset
//     req          in  N   level-sensitive request vector
//     grant        out N   one-hot or zero grant, registered
//     grant_valid  out 1   |grant, registered
//     grant_id     out IW  owner index, 0 when no grant
//     timeout      out 1   pulse with the grant that follows a forced rotation
// ---------------------------------------------------------------------------
module req_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req,
  output logic [N-1:0]           grant,
  output logic                   grant_valid,
  output logic [idx_w(N)-1:0]    grant_id,
  output logic                   timeout
);

  localparam int IW = idx_w(N);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  arb_state_e       state_q,       state_d;
  logic [N-1:0]     grant_q,       grant_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IW-1:0]    grant_id_q,    grant_id_d;
  logic             timeout_q,     timeout_d;
  logic [CNT_W-1:0] hold_cnt_q,    hold_cnt_d;
  logic [IW-1:0]    last_ptr_q,    last_ptr_d;

  logic [N-1:0]     pick_onehot;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             owner_req;

  // The current owner is never eligible for the next pick; in IDLE grant_q is
  // zero so everybody is eligible.
  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .req      (req),
    .mask     (~grant_q),
    .last_ptr (last_ptr_q),
    .onehot   (pick_onehot),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // Owner still asking for the resource.
  always_comb begin
    owner_req = |(req & grant_q);
  end

  // Next-state and next-output computation for the ownership FSM.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    timeout_d     = 1'b0;
    hold_cnt_d    = hold_cnt_q;
    last_ptr_d    = last_ptr_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d       = OWNED;
          grant_d       = pick_onehot;
          grant_valid_d = 1'b1;
          grant_id_d    = pick_idx;
          hold_cnt_d    = HOLD_ONE;
          last_ptr_d    = pick_idx;
        end else begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_id_d    = '0;
          hold_cnt_d    = '0;
        end
      end
      OWNED: begin
        if (!owner_req) begin
          // Voluntary release: hand over with no idle gap if anyone waits.
          if (pick_any) begin
            grant_d       = pick_onehot;
            grant_valid_d = 1'b1;
            grant_id_d    = pick_idx;
            hold_cnt_d    = HOLD_ONE;
            last_ptr_d    = pick_idx;
          end else begin
            state_d       = IDLE;
            grant_d       = '0;
            grant_valid_d = 1'b0;
            grant_id_d    = '0;
            hold_cnt_d    = '0;
          end
        end else if (hold_cnt_q < HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end else if (pick_any) begin
          // Hold budget spent and someone else waits: forced rotation.
          grant_d       = pick_onehot;
          grant_valid_d = 1'b1;
          grant_id_d    = pick_idx;
          hold_cnt_d    = HOLD_ONE;
          last_ptr_d    = pick_idx;
          timeout_d     = 1'b1;
        end else begin
          // Alone at the limit: keep the grant, counter stays saturated.
          hold_cnt_d = HOLD_MAX;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = '0;
        hold_cnt_d    = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      timeout_q     <= 1'b0;
      hold_cnt_q    <= '0;
      last_ptr_q    <= IW'(N - 1);
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      timeout_q     <= timeout_d;
      hold_cnt_q    <= hold_cnt_d;
      last_ptr_q    <= last_ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_req_grant_arbiter.sv
// ---------------------------------------------------------------------------
// tb_req_grant_arbiter
//   Scoreboard bench: the driver applies req/rst_n on the falling edge, steps
//   an owner/hold reference model and queues the expected outputs; a monitor
//   pops one entry after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_req_grant_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [1:0]   id;
    logic         valid;
    logic         to;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic         timeout;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  // reference model: who owns, for how long, who won last
  int m_owner;
  int m_hold;
  int m_last;
  int m_to;

  req_grant_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // First requester at or after last+1 (wrapping), skipping 'excl'; -1 if none.
  function automatic int rr_next(input logic [N-1:0] r, input int last, input int excl);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rn, input logic [N-1:0] r);
    int w;
    m_to = 0;
    if (!rn) begin
      m_owner = -1; m_hold = 0; m_last = N - 1;
    end else if (m_owner < 0) begin
      w = rr_next(r, m_last, -1);
      if (w >= 0) begin m_owner = w; m_hold = 1; m_last = w; end
    end else if (!r[m_owner]) begin
      w = rr_next(r, m_last, m_owner);
      m_owner = w;
      if (w >= 0) begin m_hold = 1; m_last = w; end
      else m_hold = 0;
    end else if (m_hold < MAX_HOLD) begin
      m_hold = m_hold + 1;
    end else begin
      w = rr_next(r, m_last, m_owner);
      if (w >= 0) begin m_owner = w; m_hold = 1; m_last = w; m_to = 1; end
    end
  endtask

  // Apply one cycle of stimulus and queue what the next rising edge must show.
  task automatic drive(input logic rn, input logic [N-1:0] r);
    exp_t e;
    rst_n = rn;
    req   = r;
    model_step(rn, r);
    e.grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e.id    = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.valid = (m_owner >= 0);
    e.to    = (m_to != 0);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic hold_req(input logic [N-1:0] r, input int cycles);
    for (int c = 0; c < cycles; c++) drive(1'b1, r);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors = vectors + 1;
      if (grant !== e.grant || grant_id !== e.id || grant_valid !== e.valid || timeout !== e.to) begin
        miscompares = miscompares + 1;
        $display("FAIL outputs @%0t: got grant=%b id=%0d valid=%b to=%b, want grant=%b id=%0d valid=%b to=%b",
                 $time, grant, grant_id, grant_valid, timeout, e.grant, e.id, e.valid, e.to);
      end
    end
  end

  // Protocol properties on the DUT outputs.
  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  for (genvar gi = 0; gi < N; gi++) begin : g_sva
    assert property (@(posedge clk) disable iff (!rst_n)
      grant[gi] |-> $past(req[gi]));
    assert property (@(posedge clk) disable iff (!rst_n)
      (!grant_valid && $rose(req[gi]) && req == (N'(1) << gi)) |=> grant[gi]);
  end

  initial begin
    logic [N-1:0] r;
    int           drain;
    vectors     = 0;
    miscompares = 0;
    m_owner = -1; m_hold = 0; m_last = N - 1; m_to = 0;
    r = '0;

    // reset
    drive(1'b0, 4'b0000);
    drive(1'b0, 4'b0000);
    // T1: single requester, rise then drop
    hold_req(4'b0000, 1);
    hold_req(4'b0001, 4);
    hold_req(4'b0000, 2);
    // T2: two requesters, owner drops, zero-gap handover
    hold_req(4'b0101, 3);
    hold_req(4'b0100, 3);
    hold_req(4'b0000, 2);
    // T3: forced rotation every MAX_HOLD cycles
    drive(1'b0, 4'b0000);
    hold_req(4'b0011, 14);
    hold_req(4'b0000, 2);
    // T4: lone requester saturates, no timeout
    hold_req(4'b1000, 40);
    // T5: wrap from owner 3 to requester 0
    hold_req(4'b1001, 2);
    hold_req(4'b0001, 2);
    hold_req(4'b0000, 1);
    // T6: reset mid-grant, then all request
    hold_req(4'b0100, 3);
    drive(1'b0, 4'b0100);
    hold_req(4'b1111, 12);
    hold_req(4'b0000, 2);

    // random: sticky requests with occasional reset
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3, 0) == 0) r[b] = ~r[b];
      end
      drive(($urandom_range(63, 0) != 0), r);
    end

    // drain the scoreboard, bounded
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      #2;
      drain = drain + 1;
    end
    if (exp_q.size() > 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
